axi_slave_req_arbiter: RTL

Arbitrates the single PCIe TL TX request port between the AXI slave read-request pop FSM (AR path) and the write-request pop FSM (AW+W path).
- Issues `axi_req_rd_grant` / `axi_req_wr_grant` back to the pop FSMs.
- Round-robin fairness; only one owner at a time.
- A write owner holds the port across all data beats of its TLP; a read owner holds it for exactly one cycle.
- Sits between the slave request pop FSMs and the TL TX arbiter/TLP builder.

---
 rtl/axi_slave_req_arbiter_pkg.sv | 15 +
 rtl/axi_slave_req_arbiter_if.sv | 27 ++
 rtl/axi_slave_req_arbiter_rr_pick.sv | 21 ++
 rtl/axi_slave_req_arbiter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/axi_slave_req_arbiter_pkg.sv
// rtl/axi_slave_req_arbiter_pkg.sv - shared types and constants for the AXI slave request arbiter
package axi_slave_package;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_RD_GNT = 2'd1,
        ARB_WR_GNT = 2'd2
    } arb_state_t;

    localparam logic ARB_OWNER_RD = 1'b0;
    localparam logic ARB_OWNER_WR = 1'b1;

    localparam int ARB_MAX_WR_BEATS = 32;

endpackage

// File: rtl/axi_slave_req_arbiter_if.sv
// rtl/axi_slave_req_arbiter_if.sv - request/grant bundle between pop FSMs, TL TX and the arbiter
interface axi_slave_req_arbiter_if #(
    parameter int BEAT_CNT_W = 6
);
    logic                  rd_req;
    logic                  wr_req;
    logic [BEAT_CNT_W-1:0] wr_beats;
    logic                  tl_ready;
    logic                  axi_req_rd_grant;
    logic                  axi_req_wr_grant;
    logic                  wr_beat_accept;
    logic                  arb_busy;
    logic                  arb_owner;
    logic                  len_err;

    modport master (
        output rd_req, wr_req, wr_beats, tl_ready,
        input  axi_req_rd_grant, axi_req_wr_grant, wr_beat_accept,
               arb_busy, arb_owner, len_err
    );

    modport slave (
        input  rd_req, wr_req, wr_beats, tl_ready,
        output axi_req_rd_grant, axi_req_wr_grant, wr_beat_accept,
               arb_busy, arb_owner, len_err
    );
endinterface

// File: rtl/axi_slave_req_arbiter_rr_pick.sv
// rtl/axi_slave_req_arbiter_rr_pick.sv - two-way read/write selector; AXI_ARB_RD_PRIORITY_EN selects strict read priority
module arb_rr_pick
    import axi_slave_package::*;
(
    input  logic rd_req,
    input  logic wr_req,
    input  logic arb_owner,
    input  logic starve,
    output logic pick_rd,
    output logic pick_wr
);

`ifdef AXI_ARB_RD_PRIORITY_EN
    assign pick_wr = wr_req & (~rd_req | starve);
`else
    // On a tie the side that did not own the port last wins.
    assign pick_wr = wr_req & (~rd_req | starve | (arb_owner == ARB_OWNER_RD));
`endif
    assign pick_rd = rd_req & ~pick_wr;

endmodule

// File: rtl/axi_slave_req_arbiter.sv
// rtl/axi_slave_req_arbiter.sv - round-robin owner of the TL TX request port; AXI_ARB_RD_PRIORITY_EN adds read priority with write-starvation guard
module axi_slave_req_arbiter
    import axi_slave_package::*;
#(
    parameter int MAX_WR_BEATS    = ARB_MAX_WR_BEATS,
    parameter int BEAT_CNT_W      = $clog2(MAX_WR_BEATS + 1)
`ifdef AXI_ARB_RD_PRIORITY_EN
    ,
    parameter int RD_STARVE_LIMIT = 4
`endif
) (
    input logic                    clk,
    input logic                    ARESTn,
    axi_slave_req_arbiter_if.slave bus
);

    arb_state_t            state;
    arb_state_t            state_next;
    logic [BEAT_CNT_W-1:0] beat_cnt;
    logic                  owner;
    logic                  len_err_q;
    logic                  pick_rd;
    logic                  pick_wr;
    logic                  starve;
    logic                  decide;
    logic                  beats_bad;
    logic                  last_beat;

    assign decide    = bus.tl_ready & (bus.rd_req | bus.wr_req);
    assign beats_bad = (bus.wr_beats == '0) || (bus.wr_beats > BEAT_CNT_W'(MAX_WR_BEATS));
    assign last_beat = bus.tl_ready && (beat_cnt == BEAT_CNT_W'(1));

`ifdef AXI_ARB_RD_PRIORITY_EN
    localparam int STARVE_W = $clog2(RD_STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] starve_cnt;

    assign starve = (starve_cnt >= STARVE_W'(RD_STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (!ARESTn) begin
            starve_cnt <= '0;
        end else if (state == ARB_IDLE && decide) begin
            if (pick_wr) begin
                starve_cnt <= '0;
            end else if (bus.wr_req && !starve) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end
        end
    end
`else
    assign starve = 1'b0;
`endif

    arb_rr_pick u_pick (
        .rd_req   (bus.rd_req),
        .wr_req   (bus.wr_req),
        .arb_owner(owner),
        .starve   (starve),
        .pick_rd  (pick_rd),
        .pick_wr  (pick_wr)
    );

    always_ff @(posedge clk) begin
        if (!ARESTn) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE: begin
                if (decide && pick_rd) begin
                    state_next = ARB_RD_GNT;
                end else if (decide && pick_wr) begin
                    state_next = ARB_WR_GNT;
                end
            end
            ARB_RD_GNT: state_next = ARB_IDLE;
            ARB_WR_GNT: begin
                if (last_beat) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        bus.axi_req_rd_grant = (state == ARB_RD_GNT);
        bus.axi_req_wr_grant = (state == ARB_WR_GNT);
        bus.arb_busy         = (state != ARB_IDLE);
        bus.wr_beat_accept   = (state == ARB_WR_GNT) & bus.tl_ready;
        bus.arb_owner        = owner;
        bus.len_err          = len_err_q;
    end

    // A bad beat count is flagged and the TLP is treated as one beat so the port frees up.
    always_ff @(posedge clk) begin
        if (!ARESTn) begin
            owner     <= ARB_OWNER_WR;
            beat_cnt  <= '0;
            len_err_q <= 1'b0;
        end else if (state == ARB_IDLE && decide) begin
            if (pick_rd) begin
                owner <= ARB_OWNER_RD;
            end else if (pick_wr) begin
                owner <= ARB_OWNER_WR;
                if (beats_bad) begin
                    len_err_q <= 1'b1;
                    beat_cnt  <= BEAT_CNT_W'(1);
                end else begin
                    beat_cnt  <= bus.wr_beats;
                end
            end
        end else if (state == ARB_WR_GNT && bus.tl_ready) begin
            beat_cnt <= beat_cnt - BEAT_CNT_W'(1);
        end
    end

endmodule
